// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-master SRAM arbiter.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam int PORT_IFETCH = 0;
  localparam int PORT_DATA   = 1;
  localparam int NUM_PORTS   = 2;

endpackage

// File: rtl/sram_arb_rr.sv
// Two-way round-robin grant: contested requests go to the master not served last.
module sram_arb_rr
  import sram_arb_pkg::*;
(
  input  logic                 pclk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 update,
  output logic                 gnt_idx,
  output logic                 gnt_valid
);

  logic last_reg;

  always_comb begin
    gnt_valid = |req;
    if (req[PORT_IFETCH] && req[PORT_DATA])
      gnt_idx = ~last_reg;
    else
      gnt_idx = req[PORT_DATA];
  end

  // Starts at PORT_DATA so the first contested grant goes to instruction fetch.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst)
      last_reg <= 1'b1;
    else if (update)
      last_reg <= gnt_idx;
  end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates an instruction-fetch and a data master onto one APB-style SRAM port
// with a bounded wait in ACCESS that completes with error on expiry.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  pclk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] m0_paddr,
  input  logic [DATA_WIDTH-1:0] m0_pdata,
  input  logic                  m0_psel,
  input  logic                  m0_pwrite,
  input  logic [3:0]            m0_pstb,
  output logic [DATA_WIDTH-1:0] m0_prdata,
  output logic                  m0_pready,
  output logic                  m0_perr,
  input  logic [ADDR_WIDTH-1:0] m1_paddr,
  input  logic [DATA_WIDTH-1:0] m1_pdata,
  input  logic                  m1_psel,
  input  logic                  m1_pwrite,
  input  logic [3:0]            m1_pstb,
  output logic [DATA_WIDTH-1:0] m1_prdata,
  output logic                  m1_pready,
  output logic                  m1_perr,
  output logic [ADDR_WIDTH-1:0] s_paddr,
  output logic [DATA_WIDTH-1:0] s_pdata,
  output logic                  s_psel,
  output logic                  s_penable,
  output logic                  s_pwrite,
  output logic [3:0]            s_pstb,
  input  logic [DATA_WIDTH-1:0] s_prdata,
  input  logic                  s_pready,
  input  logic                  s_perr
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  state_t                state_reg;
  logic [CW-1:0]         cnt_reg;
  logic                  gnt_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic                  write_reg;
  logic [3:0]            stb_reg;
  logic                  psel_reg;
  logic                  penable_reg;

  logic [ADDR_WIDTH-1:0] paddr_arr  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] pdata_arr  [NUM_PORTS];
  logic [3:0]            pstb_arr   [NUM_PORTS];
  logic [DATA_WIDTH-1:0] prdata_arr [NUM_PORTS];
  logic [NUM_PORTS-1:0]  psel_vec;
  logic [NUM_PORTS-1:0]  pwrite_vec;
  logic [NUM_PORTS-1:0]  pready_vec;
  logic [NUM_PORTS-1:0]  perr_vec;

  logic gnt_idx;
  logic gnt_valid;
  logic done;
  logic timed_out;

  assign paddr_arr[PORT_IFETCH] = m0_paddr;
  assign paddr_arr[PORT_DATA]   = m1_paddr;
  assign pdata_arr[PORT_IFETCH] = m0_pdata;
  assign pdata_arr[PORT_DATA]   = m1_pdata;
  assign pstb_arr[PORT_IFETCH]  = m0_pstb;
  assign pstb_arr[PORT_DATA]    = m1_pstb;
  assign psel_vec               = {m1_psel, m0_psel};
  assign pwrite_vec             = {m1_pwrite, m0_pwrite};

  sram_arb_rr u_rr (
    .pclk      (pclk),
    .rst       (rst),
    .req       (psel_vec),
    .update    ((state_reg == IDLE) && gnt_valid),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  assign timed_out = !s_pready && (cnt_reg == CNT_MAX);
  assign done      = (state_reg == ACCESS) && (s_pready || cnt_reg == CNT_MAX);

  // A master that withdrew its request mid-transfer gets no completion.
  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_resp
      assign pready_vec[gi] = done && (gnt_reg == 1'(gi)) && psel_vec[gi];
      assign perr_vec[gi]   = pready_vec[gi] && (s_perr || timed_out);
      assign prdata_arr[gi] = pready_vec[gi] ? s_prdata : '0;
    end
  endgenerate

  assign m0_pready = pready_vec[PORT_IFETCH];
  assign m0_perr   = perr_vec[PORT_IFETCH];
  assign m0_prdata = prdata_arr[PORT_IFETCH];
  assign m1_pready = pready_vec[PORT_DATA];
  assign m1_perr   = perr_vec[PORT_DATA];
  assign m1_prdata = prdata_arr[PORT_DATA];

  assign s_paddr   = addr_reg;
  assign s_pdata   = data_reg;
  assign s_pwrite  = write_reg;
  assign s_pstb    = stb_reg;
  assign s_psel    = psel_reg;
  assign s_penable = penable_reg;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      gnt_reg     <= 1'b0;
      addr_reg    <= '0;
      data_reg    <= '0;
      write_reg   <= 1'b0;
      stb_reg     <= '0;
      psel_reg    <= 1'b0;
      penable_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (gnt_valid) begin
            gnt_reg   <= gnt_idx;
            addr_reg  <= paddr_arr[gnt_idx];
            data_reg  <= pdata_arr[gnt_idx];
            write_reg <= pwrite_vec[gnt_idx];
            stb_reg   <= pstb_arr[gnt_idx];
            cnt_reg   <= '0;
            psel_reg  <= 1'b1;
            state_reg <= SETUP;
          end
        end
        SETUP: begin
          penable_reg <= 1'b1;
          state_reg   <= ACCESS;
        end
        ACCESS: begin
          // The slave bus reads as zero whenever the arbiter is idle.
          if (done) begin
            addr_reg    <= '0;
            data_reg    <= '0;
            write_reg   <= 1'b0;
            stb_reg     <= '0;
            cnt_reg     <= '0;
            psel_reg    <= 1'b0;
            penable_reg <= 1'b0;
            state_reg   <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: SRAM stub with byte strobes, stall and error knobs.
module tb_sram_arbiter;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;

  logic pclk = 1'b0;
  logic rst;
  always #5 pclk = ~pclk;

  logic [AW-1:0] m_paddr  [2];
  logic [DW-1:0] m_pdata  [2];
  logic          m_psel   [2];
  logic          m_pwrite [2];
  logic [3:0]    m_pstb   [2];

  logic [DW-1:0] m0_prdata, m1_prdata;
  logic          m0_pready, m1_pready, m0_perr, m1_perr;
  logic [AW-1:0] s_paddr;
  logic [DW-1:0] s_pdata, s_prdata;
  logic          s_psel, s_penable, s_pwrite, s_pready, s_perr;
  logic [3:0]    s_pstb;

  logic        stall, slv_err;
  logic [31:0] mem [64];

  sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TIMEOUT)) dut (
    .pclk      (pclk),
    .rst       (rst),
    .m0_paddr  (m_paddr[0]),
    .m0_pdata  (m_pdata[0]),
    .m0_psel   (m_psel[0]),
    .m0_pwrite (m_pwrite[0]),
    .m0_pstb   (m_pstb[0]),
    .m0_prdata (m0_prdata),
    .m0_pready (m0_pready),
    .m0_perr   (m0_perr),
    .m1_paddr  (m_paddr[1]),
    .m1_pdata  (m_pdata[1]),
    .m1_psel   (m_psel[1]),
    .m1_pwrite (m_pwrite[1]),
    .m1_pstb   (m_pstb[1]),
    .m1_prdata (m1_prdata),
    .m1_pready (m1_pready),
    .m1_perr   (m1_perr),
    .s_paddr   (s_paddr),
    .s_pdata   (s_pdata),
    .s_psel    (s_psel),
    .s_penable (s_penable),
    .s_pwrite  (s_pwrite),
    .s_pstb    (s_pstb),
    .s_prdata  (s_prdata),
    .s_pready  (s_pready),
    .s_perr    (s_perr)
  );

  // SRAM stub: zero-wait unless stalled; contents restored on every reset.
  assign s_pready = s_psel && s_penable && !stall;
  assign s_perr   = s_psel && s_penable && slv_err;
  assign s_prdata = (s_psel && s_penable && !s_pwrite) ? mem[s_paddr[7:2]] : '0;

  always @(posedge pclk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
      mem[4] <= 32'hDEADBEEF;
    end else if (s_pready && s_pwrite) begin
      for (int b = 0; b < 4; b++)
        if (s_pstb[b]) mem[s_paddr[7:2]][8*b +: 8] <= s_pdata[8*b +: 8];
    end
  end

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic push(int port, logic [31:0] rdata, logic err);
    exp_t e;
    e.port = port; e.rdata = rdata; e.err = err;
    sb.push_back(e);
  endtask

  // Every completion is matched against the oldest expectation.
  always @(negedge pclk) begin
    if (!rst) begin
      if (!m0_pready) chk("m0_prdata_zero", 64'(m0_prdata), 64'd0);
      if (!m1_pready) chk("m1_prdata_zero", 64'(m1_prdata), 64'd0);
      chk("pready_onehot", 64'(m0_pready & m1_pready), 64'd0);
      if (m0_pready || m1_pready) begin
        if (sb.size() == 0) begin
          chk("unexpected_pready", 64'(sb.size()), 64'd1);
        end else begin
          mon_e = sb.pop_front();
          $display("t=%0t done port=%0d rdata=0x%08h perr=%0b", $time,
                   m1_pready ? 1 : 0, m1_pready ? m1_prdata : m0_prdata,
                   m1_pready ? m1_perr : m0_perr);
          chk("port", 64'(m1_pready), 64'(mon_e.port));
          chk("rdata", 64'(m1_pready ? m1_prdata : m0_prdata), 64'(mon_e.rdata));
          chk("perr", 64'(m1_pready ? m1_perr : m0_perr), 64'(mon_e.err));
        end
      end
    end
  end

  task automatic drive(int p, bit wr, logic [31:0] a, logic [31:0] d, logic [3:0] stb);
    m_paddr[p] = a; m_pdata[p] = d; m_pwrite[p] = wr; m_pstb[p] = stb; m_psel[p] = 1'b1;
  endtask

  task automatic wait_ready(int p, int exp_lat, string tag);
    int cyc = 0;
    bit got = 1'b0;
    while (!got && cyc < 64) begin
      @(negedge pclk);
      cyc++;
      got = (p == 0) ? m0_pready : m1_pready;
    end
    chk(tag, 64'(cyc), 64'(exp_lat));
    @(posedge pclk);
    #1 m_psel[p] = 1'b0;
  endtask

  task automatic xfer(int p, bit wr, logic [31:0] a, logic [31:0] d, logic [3:0] stb,
                      logic [31:0] rexp, logic eexp, int lat, string tag);
    push(p, rexp, eexp);
    @(posedge pclk);
    #1 drive(p, wr, a, d, stb);
    wait_ready(p, lat, tag);
  endtask

  task automatic do_reset();
    @(negedge pclk);
    rst = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    rst = 1'b0;
  endtask

  task automatic contention();
    push(0, 32'h0, 1'b0);
    push(1, 32'h0, 1'b0);
    @(posedge pclk);
    #1;
    drive(0, 1'b0, 32'h20, 32'h0, 4'hF);
    drive(1, 1'b1, 32'h24, 32'h11223344, 4'hF);
    fork
      wait_ready(0, 3, "cont_m0_latency");
      wait_ready(1, 6, "cont_m1_latency");
    join
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int cyc;
    rst = 1'b1; stall = 1'b0; slv_err = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_paddr[i] = '0; m_pdata[i] = '0; m_psel[i] = 1'b0; m_pwrite[i] = 1'b0; m_pstb[i] = '0;
    end
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    chk("rst_s_psel", 64'(s_psel), 64'd0);
    chk("rst_s_paddr", 64'(s_paddr), 64'd0);
    chk("rst_pready", 64'({m0_pready, m1_pready}), 64'd0);
    rst = 1'b0;

    // Lone read from instruction fetch
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 3, "m0_read_latency");

    // Simultaneous requests right after reset: fetch first, then data write
    do_reset();
    contention();
    xfer(1, 1'b0, 32'h24, 32'h0, 4'hF, 32'h11223344, 1'b0, 3, "readback_latency");

    // Both masters requesting continuously: grants alternate starting with m0
    for (int i = 0; i < 3; i++) begin
      push(0, 32'hDEADBEEF, 1'b0);
      push(1, 32'h11223344, 1'b0);
    end
    @(posedge pclk);
    #1;
    drive(0, 1'b0, 32'h10, 32'h0, 4'hF);
    drive(1, 1'b0, 32'h24, 32'h0, 4'hF);
    seen = 0; cyc = 0;
    while (seen < 6 && cyc < 200) begin
      @(negedge pclk);
      cyc++;
      if (m0_pready || m1_pready) seen++;
    end
    chk("fair_count", 64'(seen), 64'd6);
    @(posedge pclk);
    #1 m_psel[0] = 1'b0; m_psel[1] = 1'b0;

    // Slave never ready: forced error completion, then normal service resumes
    stall = 1'b1;
    xfer(1, 1'b0, 32'h40, 32'h0, 4'hF, 32'h0, 1'b1, TIMEOUT + 2, "timeout_latency");
    stall = 1'b0;
    xfer(1, 1'b0, 32'h24, 32'h0, 4'hF, 32'h11223344, 1'b0, 3, "post_timeout_latency");

    // Slave error passes through
    slv_err = 1'b1;
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b1, 3, "slverr_latency");
    slv_err = 1'b0;

    // Requester withdraws after SETUP: slave completes, nobody sees pready
    @(posedge pclk);
    #1 drive(0, 1'b0, 32'h10, 32'h0, 4'hF);
    @(negedge pclk);
    @(negedge pclk);
    chk("drop_setup_psel", 64'(s_psel & !s_penable), 64'd1);
    @(posedge pclk);
    #1 m_psel[0] = 1'b0;
    @(negedge pclk);
    chk("drop_access_done", 64'(s_penable & s_pready), 64'd1);
    repeat (3) @(negedge pclk);
    chk("drop_back_idle", 64'(s_psel), 64'd0);

    // Single-byte write then full-word readback
    xfer(1, 1'b1, 32'h8, 32'hAABBCCDD, 4'h2, 32'h0, 1'b0, 3, "bytewr_latency");
    xfer(0, 1'b0, 32'h8, 32'h0, 4'hF, 32'h0000CC00, 1'b0, 3, "byterd_latency");

    // Reset while in ACCESS drops the transfer and restores fetch priority
    stall = 1'b1;
    @(posedge pclk);
    #1 drive(0, 1'b0, 32'h10, 32'h0, 4'hF);
    repeat (3) @(negedge pclk);
    chk("pre_rst_penable", 64'(s_penable), 64'd1);
    chk("pre_rst_paddr", 64'(s_paddr), 64'h10);
    #1 rst = 1'b1;
    #1;
    chk("midrst_s_psel", 64'(s_psel), 64'd0);
    chk("midrst_s_penable", 64'(s_penable), 64'd0);
    chk("midrst_s_paddr", 64'(s_paddr), 64'd0);
    chk("midrst_s_pstb", 64'(s_pstb), 64'd0);
    chk("midrst_m0_pready", 64'(m0_pready), 64'd0);
    chk("midrst_m0_prdata", 64'(m0_prdata), 64'd0);
    m_psel[0] = 1'b0;
    stall = 1'b0;
    @(posedge pclk);
    @(negedge pclk);
    rst = 1'b0;
    contention();

    repeat (4) @(negedge pclk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
